// File: rtl/hex_counter_display_if.sv
// Board-side bundle for the hex counter/display block: raw buttons and switches in,
// seven-segment digits and status out.
interface hex_counter_display_if #(
   parameter int DIGITS = 6
);
   logic [1:0]          BTN;
   logic [9:0]          SW;
   logic [8*DIGITS-1:0] HEX;
   logic                RUN_LED;
   logic                WRAP;

   modport master (
      output BTN,
      output SW,
      input  HEX,
      input  RUN_LED,
      input  WRAP
   );

   modport slave (
      input  BTN,
      input  SW,
      output HEX,
      output RUN_LED,
      output WRAP
   );
endinterface

// File: rtl/hex_counter_display.sv
// Debounced two-button hex counter with manual step, free-running prescaled mode,
// switch load, and registered active-low seven-segment output.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_STOP | counter steps on the step button or loads from switches
// ST_RUN  | counter steps on every prescaler terminal count
module hex_counter_display #(
   parameter int DIGITS          = 6,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TICK_CYCLES     = 50000000,
   parameter int BLANK_LZ        = 1
) (
   input  logic                  CLK1,
   input  logic                  RST,
   hex_counter_display_if.slave  io
);
   localparam int CW  = 4 * DIGITS;
   localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int PSW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_CYCLES - 1);

   typedef enum logic {ST_STOP, ST_RUN} state_t;

   state_t              state_q, state_d;
   logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]          acc_q, acc_d, press_q, press_d;
   logic [DBW-1:0]      db_cnt_q [2];
   logic [DBW-1:0]      db_cnt_d [2];
   logic [PSW-1:0]      presc_q, presc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                wrap_q, wrap_d, run_led_q, run_led_d, do_step;
   logic [8*DIGITS-1:0] hex_q, hex_d;

   function automatic logic [7:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
         4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
         4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
         4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
      endcase
   endfunction

   // Walk from the top digit down so "all higher nibbles zero" accumulates in lz.
   function automatic logic [8*DIGITS-1:0] disp(input logic [CW-1:0] v);
      logic lz;
      disp = '1;
      lz   = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         lz = lz & (v[4*k +: 4] == 4'h0);
         if (BLANK_LZ != 0 && k != 0 && lz) disp[8*k +: 8] = 8'hFF;
         else                               disp[8*k +: 8] = seg7(v[4*k +: 4]);
      end
   endfunction

   always_comb begin
      sync1_d = io.BTN;
      sync2_d = sync1_q;
      acc_d   = acc_q;
      press_d = '0;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != acc_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) acc_d[i] = sync2_q[i];
            else                        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
         end
         press_d[i] = acc_q[i] & ~acc_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = '0;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      do_step = 1'b0;
      case (state_q)
         ST_STOP: begin
            if (press_q[1]) state_d = ST_RUN;
            if (io.SW[8]) cnt_d = CW'(io.SW[7:0]);
            else          do_step = press_q[0];
         end
         ST_RUN: begin
            if (press_q[1]) state_d = ST_STOP;
            if (presc_q == PS_LAST) do_step = 1'b1;
            else                    presc_d = presc_q + PSW'(1);
         end
         default: state_d = ST_STOP;
      endcase
      if (do_step) begin
         if (io.SW[9]) begin
            cnt_d  = cnt_q - CW'(1);
            wrap_d = (cnt_q == '0);
         end else begin
            cnt_d  = cnt_q + CW'(1);
            wrap_d = &cnt_q;
         end
      end
      run_led_d = (state_d == ST_RUN);
      hex_d     = disp(cnt_q);
   end

   always_ff @(posedge CLK1 or posedge RST) begin
      if (RST) begin
         state_q   <= ST_STOP;
         sync1_q   <= 2'b11;
         sync2_q   <= 2'b11;
         acc_q     <= 2'b11;
         press_q   <= 2'b00;
         db_cnt_q  <= '{default: '0};
         presc_q   <= '0;
         cnt_q     <= '0;
         wrap_q    <= 1'b0;
         run_led_q <= 1'b0;
         hex_q     <= disp('0);
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         acc_q     <= acc_d;
         press_q   <= press_d;
         db_cnt_q  <= db_cnt_d;
         presc_q   <= presc_d;
         cnt_q     <= cnt_d;
         wrap_q    <= wrap_d;
         run_led_q <= run_led_d;
         hex_q     <= hex_d;
      end
   end

   assign io.HEX     = hex_q;
   assign io.RUN_LED = run_led_q;
   assign io.WRAP    = wrap_q;
endmodule

// File: tb/tb_hex_counter_display.sv
// Directed bench for hex_counter_display with DIGITS=2, DEBOUNCE_CYCLES=4, TICK_CYCLES=5.
module tb_hex_counter_display;
   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   hex_counter_display_if #(.DIGITS(2)) bus ();

   hex_counter_display #(
      .DIGITS(2), .DEBOUNCE_CYCLES(4), .TICK_CYCLES(5), .BLANK_LZ(1)
   ) dut (
      .CLK1 (clk),
      .RST  (rst),
      .io   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_hex(input string tag, input logic [15:0] exp);
      check(tag, {16'h0, bus.HEX}, {16'h0, exp});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst     = 1'b1;
      bus.BTN = 2'b11;
      bus.SW  = 10'h000;
      step(3);
      chk_hex("rst_hex", 16'hFFC0);
      check("rst_led", {31'h0, bus.RUN_LED}, 32'h0);
      check("rst_wrap", {31'h0, bus.WRAP}, 32'h0);
      rst = 1'b0;
      step(3);
      chk_hex("post_rst_hex", 16'hFFC0);

      // load 0x35, persists after load enable drops; 0x07 shows blanked leading zero
      bus.SW = 10'h135; step(3);
      chk_hex("load35", 16'hB092);
      bus.SW = 10'h035; step(3);
      chk_hex("load35_hold", 16'hB092);
      bus.SW = 10'h107; step(3);
      chk_hex("load07_blank", 16'hFFF8);
      bus.SW = 10'h135; step(3);
      bus.SW = 10'h035; step(3);
      chk_hex("reload35", 16'hB092);

      // three-cycle press is too short to be accepted
      bus.BTN = 2'b10; step(3);
      bus.BTN = 2'b11; step(12);
      chk_hex("short_press", 16'hB092);

      // long press: display changes 8 cycles after the button falls
      bus.BTN = 2'b10; step(7);
      chk_hex("press_early", 16'hB092);
      step(1);
      chk_hex("press_step", 16'hB082);
      step(2);
      bus.BTN = 2'b11; step(10);
      chk_hex("press_once", 16'hB082);

      // glitch 0,1,0,0,... restarts the debounce, step lands two cycles later
      bus.BTN = 2'b10; step(1);
      bus.BTN = 2'b11; step(1);
      bus.BTN = 2'b10; step(7);
      chk_hex("glitch_early", 16'hB082);
      step(1);
      chk_hex("glitch_step", 16'hB0F8);
      step(2);
      bus.BTN = 2'b11; step(10);
      chk_hex("glitch_once", 16'hB0F8);

      // up wrap FF -> 00
      bus.SW = 10'h1FF; step(3);
      chk_hex("loadFF", 16'h8E8E);
      bus.SW = 10'h0FF; step(1);
      bus.BTN = 2'b10; step(6);
      check("upwrap_pre", {31'h0, bus.WRAP}, 32'h0);
      step(1);
      check("upwrap_pulse", {31'h0, bus.WRAP}, 32'h1);
      chk_hex("upwrap_hex_lag", 16'h8E8E);
      step(1);
      check("upwrap_post", {31'h0, bus.WRAP}, 32'h0);
      chk_hex("upwrap_hex", 16'hFFC0);
      step(2);
      bus.BTN = 2'b11; step(10);

      // down wrap 00 -> FF
      bus.SW = 10'h200;
      bus.BTN = 2'b10; step(6);
      check("dnwrap_pre", {31'h0, bus.WRAP}, 32'h0);
      step(1);
      check("dnwrap_pulse", {31'h0, bus.WRAP}, 32'h1);
      step(1);
      check("dnwrap_post", {31'h0, bus.WRAP}, 32'h0);
      chk_hex("dnwrap_hex", 16'h8E8E);
      step(2);
      bus.BTN = 2'b11; step(10);

      // run up from 0x10: entry at +7, steps land on display at +13, +18, ...
      bus.SW = 10'h110; step(3);
      bus.SW = 10'h010; step(1);
      chk_hex("load10", 16'hF9C0);
      bus.BTN = 2'b01; step(6);
      check("run_led_pre", {31'h0, bus.RUN_LED}, 32'h0);
      step(1);
      check("run_led_on", {31'h0, bus.RUN_LED}, 32'h1);
      step(3);
      bus.BTN = 2'b11; step(2);
      chk_hex("run_t12", 16'hF9C0);
      step(1);
      chk_hex("run_11", 16'hF9F9);
      step(4);
      chk_hex("run_t17", 16'hF9F9);
      step(1);
      chk_hex("run_12", 16'hF9A4);

      // step button and load enable are ignored while running
      bus.SW = 10'h155; bus.BTN = 2'b10; step(5);
      chk_hex("run_13_ign", 16'hF9B0);
      step(5);
      chk_hex("run_14_ign", 16'hF999);

      // second run/stop press halts counting at 0x15
      bus.BTN = 2'b01; bus.SW = 10'h010; step(5);
      chk_hex("run_15", 16'hF992);
      step(1);
      check("stop_led_pre", {31'h0, bus.RUN_LED}, 32'h1);
      step(1);
      check("stop_led_off", {31'h0, bus.RUN_LED}, 32'h0);
      step(3);
      bus.BTN = 2'b11; step(20);
      chk_hex("stop_hold", 16'hF992);
      check("stop_led_hold", {31'h0, bus.RUN_LED}, 32'h0);

      // down run across zero
      bus.SW = 10'h102; step(3);
      bus.SW = 10'h202; step(1);
      chk_hex("load02", 16'hFFA4);
      bus.BTN = 2'b01; step(6);
      check("dnrun_led_pre", {31'h0, bus.RUN_LED}, 32'h0);
      step(1);
      check("dnrun_led_on", {31'h0, bus.RUN_LED}, 32'h1);
      step(3);
      bus.BTN = 2'b11; step(2);
      chk_hex("dnrun_t12", 16'hFFA4);
      step(1);
      chk_hex("dnrun_01", 16'hFFF9);
      step(5);
      chk_hex("dnrun_00", 16'hFFC0);
      step(3);
      check("dnrun_wrap_pre", {31'h0, bus.WRAP}, 32'h0);
      step(1);
      check("dnrun_wrap", {31'h0, bus.WRAP}, 32'h1);
      step(1);
      check("dnrun_wrap_post", {31'h0, bus.WRAP}, 32'h0);
      chk_hex("dnrun_FF", 16'h8E8E);

      // asynchronous reset while running
      step(2);
      rst = 1'b1; #1;
      chk_hex("midrst_hex", 16'hFFC0);
      check("midrst_led", {31'h0, bus.RUN_LED}, 32'h0);
      check("midrst_wrap", {31'h0, bus.WRAP}, 32'h0);
      step(1);
      rst = 1'b0; step(20);
      chk_hex("midrst_idle_hex", 16'hFFC0);
      check("midrst_idle_led", {31'h0, bus.RUN_LED}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
